// File: rtl/i2s_rx_master.sv
// I2S master receiver: generates SCK/WS from clk_i, captures MSB-first words on SCK rising
// edges and presents left/right pairs on a valid/ready handshake with a sticky overrun flag.
module i2s_rx_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned SLOT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              sd_i,
    output logic              sck_o,
    output logic              ws_o,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              ovf_o,
    input  logic              clr_ovf_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
    localparam int unsigned K_W   = BIT_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_FIRST  = K_W'(1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(DATA_W);

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_sck;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left_hold;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;
    logic              r_valid;
    logic              r_ovf;

    logic              w_tick;
    logic              w_rise;
    logic              w_fall;
    logic              w_ws;
    logic [K_W-1:0]    w_k;
    logic              w_shift_en;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_word_done;
    logic              w_frame_done;
    logic              w_xfer;
    logic              w_load;
    logic              w_ovf_set;

    // Divider and slot-position decode; nothing advances while disabled.
    assign w_tick       = en_i && (r_div_cnt == DIV_LAST);
    assign w_rise       = w_tick && !r_sck;
    assign w_fall       = w_tick && r_sck;
    assign w_ws         = r_bit_cnt[BIT_W-1];
    assign w_k          = r_bit_cnt[K_W-1:0];
    assign w_shift_en   = w_rise && (w_k >= K_FIRST) && (w_k <= K_LAST);
    assign w_shift_next = {r_shift[DATA_W-2:0], sd_i};
    assign w_word_done  = w_rise && (w_k == K_LAST);
    assign w_frame_done = w_word_done && w_ws;

    // A completing frame may load when the output is empty or is being taken this cycle.
    assign w_xfer       = r_valid && ready_i;
    assign w_load       = w_frame_done && (!r_valid || ready_i);
    assign w_ovf_set    = w_frame_done && r_valid && !ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (!en_i) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Slot bit counter wraps naturally over the 2*SLOT_W frame; its MSB is WS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= '0;
        end else if (!en_i) begin
            r_bit_cnt <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift     <= '0;
            r_left_hold <= '0;
        end else if (!en_i) begin
            r_shift     <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
            if (w_word_done && !w_ws) begin
                r_left_hold <= w_shift_next;
            end
        end
    end

    // Output register and handshake keep working while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_left  <= '0;
            r_right <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_left  <= r_left_hold;
            r_right <= w_shift_next;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // Overrun is sticky; a coincident new overrun beats the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign sck_o   = r_sck;
    assign ws_o    = w_ws;
    assign left_o  = r_left;
    assign right_o = r_right;
    assign valid_o = r_valid;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: frame-timing arithmetic model plus handshake reference,
// vector table, directed corner sequences and randomized ready/clear/data.
module tb_i2s_rx_master;

    localparam int CD  = 2;
    localparam int CD4 = 4;
    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int V4_FIRST  = CD4 + (SW + DW) * 2 * CD4;
    localparam int V4_PERIOD = 4 * CD4 * SW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b1;
    logic          sd_i = 1'b0;
    logic          ready_i = 1'b1;
    logic          clr_ovf_i = 1'b0;
    logic          sck_o, ws_o, valid_o, ovf_o;
    logic [DW-1:0] left_o, right_o;

    logic          sd4 = 1'b0;
    logic          ready4 = 1'b1;
    logic          clr4 = 1'b0;
    logic          sck4, ws4, valid4, ovf4;
    logic [DW-1:0] left4, right4;

    i2s_rx_master #(.CLK_DIV(CD), .DATA_W(DW), .SLOT_W(SW)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sd_i(sd_i),
        .sck_o(sck_o), .ws_o(ws_o), .left_o(left_o), .right_o(right_o),
        .valid_o(valid_o), .ready_i(ready_i), .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
    );

    i2s_rx_master #(.CLK_DIV(CD4), .DATA_W(DW), .SLOT_W(SW)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sd_i(sd4),
        .sck_o(sck4), .ws_o(ws4), .left_o(left4), .right_o(right4),
        .valid_o(valid4), .ready_i(ready4), .ovf_o(ovf4), .clr_ovf_i(clr4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    vec_t          tbl [4];
    logic [DW-1:0] fl [16];
    logic [DW-1:0] fr [16];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            e = 0;
    int            fill_mode = 0;
    logic          m_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_left = '0;
    logic [DW-1:0] m_right = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    function automatic logic exp_sck(input int ec, input int cd);
        return ((ec / cd) % 2) == 1;
    endfunction

    function automatic logic exp_ws(input int ec, input int cd);
        return ((ec / (2 * cd)) % (2 * SW)) >= SW;
    endfunction

    // Microphone: bit for the SCK period that the next edge falls into.
    function automatic logic sd_bit(input int ec, input logic fillb);
        int            p, slot, k, f;
        logic [DW-1:0] w;
        p    = ec / (2 * CD);
        slot = p % (2 * SW);
        f    = (p / (2 * SW)) % 16;
        k    = slot % SW;
        w    = (slot < SW) ? fl[f] : fr[f];
        if (k >= 1 && k <= DW) return w[DW - k];
        return fillb;
    endfunction

    task automatic model_reset();
        e       = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_left  = '0;
        m_right = '0;
    endtask

    task automatic check_all();
        chk("sck", 32'(sck_o), 32'(exp_sck(e, CD)));
        chk("ws", 32'(ws_o), 32'(exp_ws(e, CD)));
        chk("valid", 32'(valid_o), 32'(m_valid));
        chk("left", 32'(left_o), 32'(m_left));
        chk("right", 32'(right_o), 32'(m_right));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("sck4", 32'(sck4), 32'(exp_sck(e, CD4)));
        chk("ws4", 32'(ws4), 32'(exp_ws(e, CD4)));
        chk("valid4", 32'(valid4), 32'(e >= V4_FIRST && ((e - V4_FIRST) % V4_PERIOD) == 0));
    endtask

    task automatic tick();
        logic fb;
        bit   cmp;
        bit   setovf;
        int   fi;
        fb = (fill_mode == 0) ? 1'b0 : (fill_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        sd_i = sd_bit(e, fb);
        @(posedge clk);
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL cycle_budget got=%0d want<=60000", cyc);
            $fatal(1, "cycle budget exceeded");
        end
        if (rst_i) begin
            model_reset();
        end else begin
            cmp    = 1'b0;
            setovf = 1'b0;
            fi     = 0;
            if (en_i) begin
                if ((e % (2 * CD)) == CD - 1 && ((e / (2 * CD)) % (2 * SW)) == SW + DW) begin
                    cmp = 1'b1;
                    fi  = (e / (2 * CD * 2 * SW)) % 16;
                end
                e++;
            end else begin
                e = 0;
            end
            if (cmp) begin
                if (!m_valid || ready_i) begin
                    m_valid = 1'b1;
                    m_left  = fl[fi];
                    m_right = fr[fi];
                end else begin
                    setovf = 1'b1;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
            if (setovf) m_ovf = 1'b1;
            else if (clr_ovf_i) m_ovf = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic run_until(input int target);
        for (int n = 0; n < 4000 && e < target; n++) tick();
        chk("reach_e", 32'(e >= target), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        for (int n = 0; n < budget && !valid_o; n++) tick();
        chk("valid_seen", 32'(valid_o), 32'd1);
    endtask

    initial begin
        tbl[0] = '{l: 24'h800001, r: 24'h7FFFFE, exp_l: 24'h800001, exp_r: 24'h7FFFFE};
        tbl[1] = '{l: 24'hFFFFFF, r: 24'h000000, exp_l: 24'hFFFFFF, exp_r: 24'h000000};
        tbl[2] = '{l: 24'h5A5A5A, r: 24'hA5A5A5, exp_l: 24'h5A5A5A, exp_r: 24'hA5A5A5};
        tbl[3] = '{l: 24'h000001, r: 24'h800000, exp_l: 24'h000001, exp_r: 24'h800000};
        for (int i = 0; i < 16; i++) begin
            fl[i] = '0;
            fr[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            fl[i] = tbl[i].l;
            fr[i] = tbl[i].r;
        end

        // Reset state, then vector table with ready held high.
        tick();
        tick();
        chk("rst_sck", 32'(sck_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_left", 32'(left_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(400);
            chk("tbl_left", 32'(left_o), 32'(tbl[i].exp_l));
            chk("tbl_right", 32'(right_o), 32'(tbl[i].exp_r));
            tick();
            chk("tbl_valid_drop", 32'(valid_o), 32'd0);
        end

        // Backpressure over two frames; clear held through the second overrun.
        en_i = 1'b0;
        ready_i = 1'b0;
        fl[0] = 24'h123456; fr[0] = 24'h654321;
        fl[1] = 24'hABCDEF; fr[1] = 24'h000001;
        fl[2] = 24'h13579B; fr[2] = 24'h2468AC;
        fl[3] = 24'hC0FFEE; fr[3] = 24'h0BADF0;
        tick();
        en_i = 1'b1;
        clr_ovf_i = 1'b1;
        run_until(481);
        tick();
        clr_ovf_i = 1'b0;
        chk("bp_ovf_setwins", 32'(ovf_o), 32'd1);
        chk("bp_left_hold", 32'(left_o), 32'h123456);
        chk("bp_right_hold", 32'(right_o), 32'h654321);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("bp_xfer_valid", 32'(valid_o), 32'd0);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("bp_ovf_clr", 32'(ovf_o), 32'd0);

        // Accept in the same cycle as the next completion.
        run_until(737);
        tick();
        chk("acc_first_left", 32'(left_o), 32'h13579B);
        run_until(993);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("acc_valid", 32'(valid_o), 32'd1);
        chk("acc_left", 32'(left_o), 32'hC0FFEE);
        chk("acc_right", 32'(right_o), 32'h0BADF0);
        chk("acc_ovf", 32'(ovf_o), 32'd0);

        // Async reset at right slot bit 10 with a frame pending.
        run_until(1193);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_left", 32'(left_o), 32'd0);
        chk("arst_right", 32'(right_o), 32'd0);
        chk("arst_sck", 32'(sck_o), 32'd0);
        chk("arst_ws", 32'(ws_o), 32'd0);
        tick();
        rst_i = 1'b0;
        fl[0] = 24'h9ABCDE; fr[0] = 24'h3C3C3C;
        ready_i = 1'b1;
        wait_valid(400);
        ready_i = 1'b0;
        chk("arst_next_left", 32'(left_o), 32'h9ABCDE);
        chk("arst_next_right", 32'(right_o), 32'h3C3C3C);

        // Disable mid right word with a frame pending; filler bits high.
        fill_mode = 1;
        run_until(402);
        en_i = 1'b0;
        fl[0] = 24'h0F0F0F; fr[0] = 24'hF0F0F1;
        tick();
        chk("dis_sck", 32'(sck_o), 32'd0);
        chk("dis_ws", 32'(ws_o), 32'd0);
        chk("dis_valid_kept", 32'(valid_o), 32'd1);
        tick();
        tick();
        ready_i = 1'b1;
        tick();
        chk("dis_xfer", 32'(valid_o), 32'd0);
        en_i = 1'b1;
        wait_valid(400);
        chk("reen_left", 32'(left_o), 32'h0F0F0F);
        chk("reen_right", 32'(right_o), 32'hF0F0F1);

        // Randomized data, ready, clear and occasional disable.
        en_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fl[i] = DW'($urandom);
            fr[i] = DW'($urandom);
        end
        tick();
        en_i = 1'b1;
        fill_mode = 2;
        for (int n = 0; n < 2500; n++) begin
            ready_i   = ($urandom_range(0, 3) != 0);
            clr_ovf_i = ($urandom_range(0, 15) == 0);
            en_i      = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
